i2c_target_regs: RTL and testbench

//   I2C target (slave) responder that sits on the same scl/sda bus as the APB-to-I2C master.
//   It exposes NREGS 8-bit registers behind a 7-bit device address, with an auto-incrementing

---
 rtl/i2c_target_regs.sv | 188 ++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing NREGS byte registers at DEV_ADDR behind an auto-incrementing pointer.
// scl/sda are oversampled on clk; bus conditions are acted on 3 clk after a pin change.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NREGS    = 16,
  parameter int         PTR_W    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_idx,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] loc_idx,
  output logic [7:0]       loc_data
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, PTR, ACK_D, WR, RD} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [7:0]       sh, sh_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             oe_nxt, busy_nxt, stb_nxt, reg_we;
  logic [PTR_W-1:0] idx_nxt;
  logic [7:0]       dat_nxt;
  logic [7:0]       regs [NREGS];

  logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx, rd_byte;

  // Synchronisers reset to the idle-high bus level so reset release creates no edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign rx        = {sh[6:0], sda_s2};
  assign rd_byte   = regs[ptr];
  assign loc_data  = regs[loc_idx];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    ptr_nxt   = ptr;
    oe_nxt    = sda_oe;
    busy_nxt  = busy;
    stb_nxt   = 1'b0;
    idx_nxt   = wr_idx;
    dat_nxt   = wr_data;
    reg_we    = 1'b0;
    if (stop_det) begin
      state_nxt = IDLE;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else if (start_det) begin
      state_nxt = ADDR;
      cnt_nxt   = 4'd0;
      oe_nxt    = 1'b0;
    end else begin
      case (state)
        ADDR, PTR: begin
          if (scl_rise) begin
            sh_nxt  = rx;
            cnt_nxt = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            if (state == PTR) begin
              ptr_nxt   = sh[PTR_W-1:0];
              oe_nxt    = 1'b1;
              state_nxt = ACK_D;
            end else if (sh[7:1] == DEV_ADDR) begin
              oe_nxt    = 1'b1;
              busy_nxt  = 1'b1;
              state_nxt = ACK_A;
            end else begin
              busy_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end
        end
        ACK_A: begin
          if (scl_fall) begin
            cnt_nxt   = 4'd0;
            // sh[0] still holds the R/W bit of the address byte
            oe_nxt    = sh[0] ? ~rd_byte[7] : 1'b0;
            state_nxt = sh[0] ? RD : PTR;
          end
        end
        ACK_D: begin
          if (scl_fall) begin
            oe_nxt    = 1'b0;
            cnt_nxt   = 4'd0;
            state_nxt = WR;
          end
        end
        WR: begin
          if (scl_rise) begin
            sh_nxt  = rx;
            cnt_nxt = cnt + 4'd1;
            if (cnt == 4'd7) begin
              reg_we  = 1'b1;
              stb_nxt = 1'b1;
              idx_nxt = ptr;
              dat_nxt = rx;
              ptr_nxt = ptr + PTR_W'(1);
            end
          end else if (scl_fall && cnt == 4'd8) begin
            oe_nxt    = 1'b1;
            state_nxt = ACK_D;
          end
        end
        RD: begin
          // cnt 1..7: data bits, 8: master ACK slot, 9: ACKed, next byte pending
          if (scl_rise) begin
            if (cnt == 4'd8) begin
              ptr_nxt = ptr + PTR_W'(1);
              cnt_nxt = 4'd9;
              if (sda_s2) begin
                oe_nxt    = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
              end
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else if (scl_fall) begin
            if (cnt < 4'd8) begin
              oe_nxt = ~rd_byte[3'd7 - cnt[2:0]];
            end else if (cnt == 4'd8) begin
              oe_nxt = 1'b0;
            end else begin
              oe_nxt  = ~rd_byte[7];
              cnt_nxt = 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      sh      <= 8'h00;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_idx  <= '0;
      wr_data <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sh      <= sh_nxt;
      ptr     <= ptr_nxt;
      sda_oe  <= oe_nxt;
      busy    <= busy_nxt;
      wr_stb  <= stb_nxt;
      wr_idx  <= idx_nxt;
      wr_data <= dat_nxt;
      if (reg_we) regs[ptr] <= rx;
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master against a transaction-level register model.
module tb_i2c_target_regs;
  localparam int Q  = 5;
  localparam int NR = 16;

  logic       clk = 1'b0;
  logic       rst, scl, sda_m, sda_bus;
  logic       sda_oe, busy, wr_stb;
  logic [3:0] wr_idx, loc_idx;
  logic [7:0] wr_data, loc_data;

  always #5 clk = ~clk;
  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe), .busy(busy),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_data(wr_data), .loc_idx(loc_idx), .loc_data(loc_data)
  );

  int          n_checks, n_errors;
  logic [7:0]  m_regs [NR];
  int          m_ptr;
  logic [7:0]  td [4];
  logic [11:0] wr_q [$];
  logic [11:0] exp_q [$];

  always @(negedge clk) if (wr_stb === 1'b1) wr_q.push_back({wr_idx, wr_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q); scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b; wait_clk(Q); scl = 1'b1; wait_clk(2*Q); scl = 1'b0; wait_clk(Q);
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    b = sda_bus; wait_clk(Q); scl = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(input logic last, output logic [7:0] d);
    logic b;
    for (int i = 0; i < 8; i++) begin
      rd_bit(b);
      d = {d[6:0], b};
    end
    wr_bit(last);
  endtask

  task automatic check_wr();
    chk("wr_count", wr_q.size(), exp_q.size());
    while (wr_q.size() > 0 && exp_q.size() > 0) chk("wr_event", wr_q.pop_front(), exp_q.pop_front());
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs();
    for (int i = 0; i < NR; i++) begin
      loc_idx = 4'(i);
      #1;
      chk("loc_data", loc_data, m_regs[i]);
    end
  endtask

  task automatic wr_trans(input logic [6:0] addr, input logic [7:0] pb, input int n);
    logic ack;
    bus_start();
    wr_byte({addr, 1'b0}, ack);
    if (addr == 7'h50) begin
      chk("addr_ack", ack, 0);
      chk("busy_on", busy, 1);
      wr_byte(pb, ack);
      chk("ptr_ack", ack, 0);
      m_ptr = int'(pb) % NR;
      for (int i = 0; i < n; i++) begin
        wr_byte(td[i], ack);
        chk("data_ack", ack, 0);
        m_regs[m_ptr] = td[i];
        exp_q.push_back({4'(m_ptr), td[i]});
        m_ptr = (m_ptr + 1) % NR;
      end
    end else begin
      chk("foreign_addr_nack", ack, 1);
      chk("foreign_busy", busy, 0);
    end
    bus_stop();
    chk("busy_after_stop", busy, 0);
    check_wr();
  endtask

  task automatic rd_trans(input logic set_ptr, input logic [7:0] pb, input int n);
    logic ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      wr_byte(8'hA0, ack);
      chk("rd_wr_addr_ack", ack, 0);
      wr_byte(pb, ack);
      chk("rd_ptr_ack", ack, 0);
      m_ptr = int'(pb) % NR;
      bus_start();
    end
    wr_byte(8'hA1, ack);
    chk("rd_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, d);
      chk("rd_data", d, m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % NR;
    end
    chk("oe_after_nack", sda_oe, 0);
    chk("busy_after_nack", busy, 0);
    bus_stop();
    check_wr();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic ack;
    logic [6:0] a;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; loc_idx = 4'd0;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    wait_clk(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_loc_data", loc_data, 0);
    rst = 1'b0;
    wait_clk(4);

    // T1: plain write of two bytes from pointer 3
    td[0] = 8'h5A; td[1] = 8'hC3;
    wr_trans(7'h50, 8'h03, 2);
    loc_idx = 4'd4; #1;
    chk("t1_loc4", loc_data, 8'hC3);

    // T2: pointer wrap from 15 to 0
    td[0] = 8'h11; td[1] = 8'h22;
    wr_trans(7'h50, 8'h0F, 2);
    check_regs();

    // T3: pointer write, repeated START, read two bytes
    rd_trans(1'b1, 8'h03, 2);

    // T4: foreign address ignored, next transfer accepted
    wr_trans(7'h58, 8'h00, 0);
    td[0] = 8'h77;
    wr_trans(7'h50, 8'h05, 1);

    // T5: reset while the target drives a 0 data bit
    bus_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h03, ack);
    bus_start();
    wr_byte(8'hA1, ack);
    chk("t5_read_ack", ack, 0);
    chk("t5_driving", sda_oe, 1);
    rst = 1'b1;
    wait_clk(1);
    chk("t5_oe_released", sda_oe, 0);
    chk("t5_busy_cleared", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    bus_stop();
    check_regs();
    rd_trans(1'b0, 8'h00, 2);

    // T6: STOP after 4 data bits commits nothing
    bus_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h07, ack);
    m_ptr = 7;
    for (int i = 0; i < 4; i++) wr_bit(1'b1);
    bus_stop();
    chk("t6_busy", busy, 0);
    check_wr();
    loc_idx = 4'd7; #1;
    chk("t6_reg7", loc_data, m_regs[7]);

    // Randomised mix of writes, reads and foreign addresses
    for (int t = 0; t < 20; t++) begin
      int k, n;
      k = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) td[i] = 8'($urandom);
      case (k)
        0: wr_trans(7'h50, 8'($urandom), n);
        1: rd_trans(1'b1, 8'($urandom), n);
        2: rd_trans(1'b0, 8'h00, n);
        default: begin
          a = 7'($urandom);
          if (a == 7'h50) a = 7'h51;
          wr_trans(a, 8'h00, 0);
        end
      endcase
    end
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
